rename_alias_table: RTL and testbench
=====================================

// Module: rename_alias_table
// PURPOSE
//  Parametrised register alias table for the dispatch stage. It merges the ARF/ROB speculative bit,
//  the ROB tag table and a per-register ready bit into one structure. Source readiness is therefore
//  tracked inside the RAT from N_WB wakeup/broadcast ports, so dispatch no longer needs ROB ready lookups.
//  Sits between decode and the IIQ/LSQ dispatch muxes. It is flushed on fetch redirect and updated at ROB retire.
// PARAMETERS
//  N_ARF         32  number of architectural registers; entry 0 (x0) is hardwired, never renamed
//  ROB_ID_WIDTH  4   width of a ROB tag
//  N_WB          2   number of wakeup/broadcast ports (e.g. IIQ wakeup, LD broadcast)
//  BYPASS        1   1: same-cycle wakeup is forwarded onto srcN_ready; 0: visible next cycle only
// PORTS  (A = $clog2(N_ARF), R = ROB_ID_WIDTH)
//  clk            in   1              clock
//  rst_aL         in   1              asynchronous active-low reset
//  rs1, rs2       in   A              source arch ids, read combinationally
//  src1_spec      out  1              1 = rs1 maps to ROB (speculative); 0 = value in ARF
//  src1_rob_id    out  R              current tag of rs1 (0 when src1_spec=0)
//  src1_ready     out  1              source value available (ARF, or ROB entry already written back)
//  src2_spec/src2_rob_id/src2_ready   out  1/R/1   same for rs2
//  rename_valid   in   1              rename rd to rename_rob_id this cycle (= dispatch & rd_valid)
//  rename_rd      in   A              destination arch id
//  rename_rob_id  in   R              ROB tag allocated to the dispatching instruction
//  retire_valid   in   1              ROB head retires this cycle
//  retire_arf_id  in   A              retiring destination arch id
//  retire_rob_id  in   R              retiring ROB tag
//  wb_valid       in   N_WB           per-port wakeup valid
//  wb_rob_id      in   N_WB*R         per-port tag, port i at [i*R +: R]
//  flush          in   1              redirect: restore every mapping to ARF
//  spec_count     out  $clog2(N_ARF+1)  number of entries currently speculative
// BEHAVIOUR
//  - Reset is asynchronous and active-low; the clock is single.
//  - Per-entry state: spec, tag[R], rdy. Reset: all spec=0, tag=0, rdy=0, spec_count=0.
//    Outputs under reset: srcN_spec=0, srcN_rob_id=0, srcN_ready=1.
//  - Reads are combinational and return pre-update state. A same-cycle rename never affects this
//    cycle's source lookups (an instruction's sources see the old mapping of its own rd).
//  - srcN_ready = ~spec | rdy | (BYPASS & spec & any(wb_valid[i] & wb_rob_id[i]==tag)).
//  - Reads of x0 always return spec=0, rob_id=0, ready=1. Renames and retires targeting x0 are ignored.
//  - Priority per entry, per clock edge: flush > rename > retire/wakeup.
//  - flush=1: all spec<=0, rdy<=0, tag<=0, spec_count<=0. Rename, retire and wb are ignored that cycle.
//  - Rename (rename_valid, rd!=0): spec<=1, tag<=rename_rob_id, rdy<=0 (a fresh tag cannot already be written back).
//  - Retire: if spec[retire_arf_id] and tag==retire_rob_id and no rename to that entry: spec<=0, rdy<=0, tag<=0.
//    A tag mismatch (entry renamed again since) leaves the entry unchanged.
//  - Wakeup: every entry with spec=1 whose tag matches any valid wb port sets rdy<=1.
//    Duplicate port matches are harmless. A rename to the same entry in that cycle wins.
//  - spec_count_next = spec_count + inc - dec.
//    inc = rename to an entry with spec=0.
//    dec = retire clears an entry and no rename targets that entry.
//    Retire and rename to the same matching entry: net 0.
//    The counter never exceeds N_ARF-1; over/underflow is a design error and must be asserted in simulation.
//  - No combinational path from rename_*/retire_*/flush to any output.
//    wb_* reaches srcN_ready only when BYPASS=1.
// TESTING
//  1 Reset mid-run: spec_count=5 and several entries spec, assert rst_aL low -> all srcN_spec=0,
//    srcN_ready=1 and spec_count=0 immediately, without waiting for a clock edge.
//  2 Rename x5->tag 3, next cycle read rs1=5 -> spec=1, rob_id=3, ready=0.
//    wb_valid[1]=1, tag 3 -> ready=1 same cycle (BYPASS=1) or next cycle (BYPASS=0).
//  3 Rename x7->tag 2, then x7->tag 6; retire x7/tag 2 -> x7 stays spec, tag 6, spec_count=1.
//    Retire x7/tag 6 -> spec=0, spec_count=0.
//  4 Same cycle: rename x9->tag 4 and read rs1=9 (previously ARF) -> read shows spec=0.
//    Next cycle shows spec=1, tag 4.
//  5 Same cycle: retire x4/tag 1 (matching) and rename x4->tag 8 -> x4 spec, tag 8, rdy=0, spec_count unchanged.
//    Rename x0 -> no state change.
//  6 Flush with 10 speculative entries while rename x3 and wb are valid -> all spec=0, spec_count=0.
//    x3 is not renamed.

Source files
------------

// File: rtl/rename_alias_table_if.sv
// Dispatch-side bundle for the rename alias table: source lookups, rename, retire, wakeup and flush.
// Master drives the requests and reads the lookups; slave is the table.
interface rename_alias_table_if #(
    parameter int N_ARF        = 32,
    parameter int ROB_ID_WIDTH = 4,
    parameter int N_WB         = 2
);
    localparam int A  = $clog2(N_ARF);
    localparam int R  = ROB_ID_WIDTH;
    localparam int CW = $clog2(N_ARF + 1);

    logic [A-1:0]      rs1;
    logic [A-1:0]      rs2;
    logic              src1_spec;
    logic [R-1:0]      src1_rob_id;
    logic              src1_ready;
    logic              src2_spec;
    logic [R-1:0]      src2_rob_id;
    logic              src2_ready;

    logic              rename_valid;
    logic [A-1:0]      rename_rd;
    logic [R-1:0]      rename_rob_id;

    logic              retire_valid;
    logic [A-1:0]      retire_arf_id;
    logic [R-1:0]      retire_rob_id;

    logic [N_WB-1:0]   wb_valid;
    logic [N_WB*R-1:0] wb_rob_id;

    logic              flush;
    logic [CW-1:0]     spec_count;

    modport master (
        output rs1, rs2, rename_valid, rename_rd, rename_rob_id,
               retire_valid, retire_arf_id, retire_rob_id, wb_valid, wb_rob_id, flush,
        input  src1_spec, src1_rob_id, src1_ready, src2_spec, src2_rob_id, src2_ready, spec_count
    );

    modport slave (
        input  rs1, rs2, rename_valid, rename_rd, rename_rob_id,
               retire_valid, retire_arf_id, retire_rob_id, wb_valid, wb_rob_id, flush,
        output src1_spec, src1_rob_id, src1_ready, src2_spec, src2_rob_id, src2_ready, spec_count
    );
endinterface

// File: rtl/rename_alias_table.sv
// Register alias table with per-entry ROB tag and ready bit; lookups are combinational (pre-update state),
// updates land on the next edge. No backpressure: every rename/retire/wakeup is accepted in its cycle.
module rename_alias_table #(
    parameter int N_ARF        = 32,
    parameter int ROB_ID_WIDTH = 4,
    parameter int N_WB         = 2,
    parameter bit BYPASS       = 1'b1
) (
    input  logic               clk,
    input  logic               rst_aL,
    rename_alias_table_if.slave rat
);
    localparam int A  = $clog2(N_ARF);
    localparam int R  = ROB_ID_WIDTH;
    localparam int CW = $clog2(N_ARF + 1);
    localparam logic [N_ARF-1:0] BIT0 = 1;

    logic [N_ARF-1:0] spec_q;
    logic [N_ARF-1:0] rdy_q;
    logic [R-1:0]     tag_q [N_ARF];
    logic [CW-1:0]    count_q;

    logic [N_ARF-1:0] wake;
    logic [N_ARF-1:0] ren_hot;
    logic [N_ARF-1:0] ret_hot;
    logic             ren_en;
    logic             ret_en;
    logic             inc;
    logic             dec;
    logic [CW-1:0]    count_d;

    function automatic logic wb_hit(input logic [R-1:0]      t,
                                    input logic [N_WB-1:0]   vld,
                                    input logic [N_WB*R-1:0] ids);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < N_WB; p++) begin
            if (vld[p] && ids[p*R +: R] == t) hit = 1'b1;
        end
        return hit;
    endfunction

    // Source lookups: x0 is forced to an always-ready architectural value.
    always_comb begin
        rat.src1_spec   = 1'b0;
        rat.src1_rob_id = '0;
        rat.src1_ready  = 1'b1;
        rat.src2_spec   = 1'b0;
        rat.src2_rob_id = '0;
        rat.src2_ready  = 1'b1;
        if (rat.rs1 != '0 && spec_q[rat.rs1]) begin
            rat.src1_spec   = 1'b1;
            rat.src1_rob_id = tag_q[rat.rs1];
            rat.src1_ready  = rdy_q[rat.rs1] ||
                              (BYPASS && wb_hit(tag_q[rat.rs1], rat.wb_valid, rat.wb_rob_id));
        end
        if (rat.rs2 != '0 && spec_q[rat.rs2]) begin
            rat.src2_spec   = 1'b1;
            rat.src2_rob_id = tag_q[rat.rs2];
            rat.src2_ready  = rdy_q[rat.rs2] ||
                              (BYPASS && wb_hit(tag_q[rat.rs2], rat.wb_valid, rat.wb_rob_id));
        end
    end

    assign rat.spec_count = count_q;

    always_comb begin
        for (int i = 0; i < N_ARF; i++) begin
            wake[i] = spec_q[i] && wb_hit(tag_q[i], rat.wb_valid, rat.wb_rob_id);
        end
    end

    always_comb begin
        ren_en  = rat.rename_valid && rat.rename_rd != '0;
        ret_en  = rat.retire_valid && rat.retire_arf_id != '0 &&
                  spec_q[rat.retire_arf_id] && tag_q[rat.retire_arf_id] == rat.retire_rob_id;
        ren_hot = ren_en ? (BIT0 << rat.rename_rd) : '0;
        ret_hot = ret_en ? (BIT0 << rat.retire_arf_id) : '0;
        inc     = ren_en && !spec_q[rat.rename_rd];
        // A rename onto the retiring entry keeps it speculative, so the count does not drop.
        dec     = ret_en && !(ren_en && rat.rename_rd == rat.retire_arf_id);
        count_d = count_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            spec_q  <= '0;
            rdy_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < N_ARF; i++) tag_q[i] <= '0;
        end else if (rat.flush) begin
            spec_q  <= '0;
            rdy_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < N_ARF; i++) tag_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < N_ARF; i++) begin
                if (ren_hot[i]) begin
                    spec_q[i] <= 1'b1;
                    tag_q[i]  <= rat.rename_rob_id;
                    rdy_q[i]  <= 1'b0;
                end else if (ret_hot[i]) begin
                    spec_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                    rdy_q[i]  <= 1'b0;
                end else if (wake[i]) begin
                    rdy_q[i]  <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_aL && !rat.flush) begin
            assert (!(inc && !dec && count_q == CW'(N_ARF - 1)));
            assert (!(dec && !inc && count_q == '0));
        end
    end
endmodule

// File: tb/tb_rename_alias_table.sv
// Directed bench for rename_alias_table with bypass enabled; expected values are hand-computed constants.
module tb_rename_alias_table;
    logic clk;
    logic rst_aL;
    int   n_tests;
    int   n_fail;

    rename_alias_table_if #(.N_ARF(32), .ROB_ID_WIDTH(4), .N_WB(2)) rat_if ();

    rename_alias_table #(.N_ARF(32), .ROB_ID_WIDTH(4), .N_WB(2), .BYPASS(1'b1)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .rat    (rat_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rat_if.rename_valid  = 1'b0;
        rat_if.rename_rd     = '0;
        rat_if.rename_rob_id = '0;
        rat_if.retire_valid  = 1'b0;
        rat_if.retire_arf_id = '0;
        rat_if.retire_rob_id = '0;
        rat_if.wb_valid      = '0;
        rat_if.wb_rob_id     = '0;
        rat_if.flush         = 1'b0;
    endtask

    task automatic rename(input int rd, input int tag);
        rat_if.rename_valid  = 1'b1;
        rat_if.rename_rd     = 5'(rd);
        rat_if.rename_rob_id = 4'(tag);
        step();
        rat_if.rename_valid  = 1'b0;
    endtask

    task automatic retire(input int rd, input int tag);
        rat_if.retire_valid  = 1'b1;
        rat_if.retire_arf_id = 5'(rd);
        rat_if.retire_rob_id = 4'(tag);
        step();
        rat_if.retire_valid  = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rat_if.rs1 = 5'd5;
        rat_if.rs2 = 5'd0;
        rst_aL = 1'b0;
        #3;
        check("rst_spec", 32'(rat_if.src1_spec), 0);
        check("rst_ready", 32'(rat_if.src1_ready), 1);
        check("rst_count", 32'(rat_if.spec_count), 0);
        @(negedge clk);
        rst_aL = 1'b1;
        step();

        // Rename x5 -> tag 3, then wake it through port 1.
        rename(5, 3);
        check("ren_spec", 32'(rat_if.src1_spec), 1);
        check("ren_tag", 32'(rat_if.src1_rob_id), 3);
        check("ren_ready", 32'(rat_if.src1_ready), 0);
        check("ren_count", 32'(rat_if.spec_count), 1);
        rat_if.wb_valid  = 2'b10;
        rat_if.wb_rob_id = {4'd3, 4'd0};
        #1;
        check("wb_bypass", 32'(rat_if.src1_ready), 1);
        step();
        rat_if.wb_valid = '0;
        #1;
        check("wb_held", 32'(rat_if.src1_ready), 1);

        // Stale retire must not clear a re-renamed entry.
        rename(7, 2);
        rename(7, 6);
        check("rr_count", 32'(rat_if.spec_count), 2);
        retire(7, 2);
        rat_if.rs2 = 5'd7;
        #1;
        check("stale_spec", 32'(rat_if.src2_spec), 1);
        check("stale_tag", 32'(rat_if.src2_rob_id), 6);
        check("stale_count", 32'(rat_if.spec_count), 2);
        retire(7, 6);
        check("ret_spec", 32'(rat_if.src2_spec), 0);
        check("ret_tag", 32'(rat_if.src2_rob_id), 0);
        check("ret_count", 32'(rat_if.spec_count), 1);

        // Same-cycle rename does not affect the lookup.
        rat_if.rs1 = 5'd9;
        rat_if.rename_valid  = 1'b1;
        rat_if.rename_rd     = 5'd9;
        rat_if.rename_rob_id = 4'd4;
        #1;
        check("same_cyc_spec", 32'(rat_if.src1_spec), 0);
        step();
        rat_if.rename_valid = 1'b0;
        #1;
        check("next_cyc_spec", 32'(rat_if.src1_spec), 1);
        check("next_cyc_tag", 32'(rat_if.src1_rob_id), 4);
        check("next_cyc_count", 32'(rat_if.spec_count), 2);

        // Retire and rename of x4 in the same cycle.
        rename(4, 1);
        rat_if.wb_valid  = 2'b01;
        rat_if.wb_rob_id = {4'd0, 4'd1};
        step();
        rat_if.wb_valid = '0;
        rat_if.rs1 = 5'd4;
        #1;
        check("x4_woken", 32'(rat_if.src1_ready), 1);
        check("x4_count", 32'(rat_if.spec_count), 3);
        rat_if.retire_valid  = 1'b1;
        rat_if.retire_arf_id = 5'd4;
        rat_if.retire_rob_id = 4'd1;
        rename(4, 8);
        rat_if.retire_valid = 1'b0;
        #1;
        check("rr4_spec", 32'(rat_if.src1_spec), 1);
        check("rr4_tag", 32'(rat_if.src1_rob_id), 8);
        check("rr4_ready", 32'(rat_if.src1_ready), 0);
        check("rr4_count", 32'(rat_if.spec_count), 3);

        // x0 is never renamed and always reads as ready ARF.
        rename(0, 5);
        rat_if.rs1 = 5'd0;
        #1;
        check("x0_spec", 32'(rat_if.src1_spec), 0);
        check("x0_tag", 32'(rat_if.src1_rob_id), 0);
        check("x0_ready", 32'(rat_if.src1_ready), 1);
        check("x0_count", 32'(rat_if.spec_count), 3);

        // Flush with 10 speculative entries while a rename and wakeup are also presented.
        for (int i = 10; i < 17; i++) rename(i, i - 8);
        check("pre_flush_count", 32'(rat_if.spec_count), 10);
        rat_if.flush         = 1'b1;
        rat_if.rename_valid  = 1'b1;
        rat_if.rename_rd     = 5'd3;
        rat_if.rename_rob_id = 4'd2;
        rat_if.wb_valid      = 2'b01;
        rat_if.wb_rob_id     = {4'd0, 4'd4};
        rat_if.rs1 = 5'd9;
        #1;
        check("flush_no_comb", 32'(rat_if.src1_spec), 1);
        step();
        idle();
        rat_if.rs1 = 5'd3;
        rat_if.rs2 = 5'd5;
        #1;
        check("flush_count", 32'(rat_if.spec_count), 0);
        check("flush_x3_spec", 32'(rat_if.src1_spec), 0);
        check("flush_x5_spec", 32'(rat_if.src2_spec), 0);
        check("flush_x5_ready", 32'(rat_if.src2_ready), 1);

        // Asynchronous reset mid-run.
        for (int i = 1; i < 6; i++) rename(i, i);
        rat_if.rs1 = 5'd1;
        rat_if.rs2 = 5'd3;
        #1;
        check("pre_rst_count", 32'(rat_if.spec_count), 5);
        check("pre_rst_spec", 32'(rat_if.src1_spec), 1);
        #2;
        rst_aL = 1'b0;
        #1;
        check("arst_count", 32'(rat_if.spec_count), 0);
        check("arst_spec1", 32'(rat_if.src1_spec), 0);
        check("arst_ready1", 32'(rat_if.src1_ready), 1);
        check("arst_spec2", 32'(rat_if.src2_spec), 0);
        check("arst_tag2", 32'(rat_if.src2_rob_id), 0);
        rst_aL = 1'b1;
        step();
        check("post_rst_count", 32'(rat_if.spec_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
